rfile2: RTL and testbench

- Register file and flag register for cpu2. It sits directly upstream and downstream of the ALU in the execute loop.
- Provides the two ALU operand buses (rb/rd values) and the current flags.
- Consumes the ALU result, the ALU output flags and the write-back/flag enables.
- Owns R15 as the program counter, with an auto-increment path for fetch.

---
 rtl/rfile2.sv | 93 +++++++++
 tb/tb_rfile2.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rfile2.sv
// Sixteen-entry register file plus 8-bit flag register for cpu2; R15 doubles as the PC.
// Define RFILE2_BYPASS_EN to forward same-cycle writes onto bo, do_val, fo and pc.
module rfile2 #(
    parameter int WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       ra_b,
    input  logic [3:0]       ra_d,
    output logic [WIDTH-1:0] bo,
    output logic [WIDTH-1:0] do_val,
    input  logic [3:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             wb_en,
    input  logic [7:0]       fi,
    input  logic             flag_en,
    output logic [7:0]       fo,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] pc,
    input  logic [3:0]       dbg_a,
    output logic [WIDTH-1:0] dbg_o
);

    localparam logic [3:0] PC_ADDR = 4'hf;

    logic [WIDTH-1:0] regs [0:15];
    logic [7:0]       flags;

    logic             wr_go;
    logic             pc_wr;
    logic             flag_go;

    assign wr_go   = en && wb_en;
    assign pc_wr   = wr_go && (wa == PC_ADDR);
    assign flag_go = en && flag_en;

    // General-purpose registers R0..R14
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_go && (wa != PC_ADDR)) begin
            regs[wa] <= wd;
        end
    end

    // R15: an explicit write-back wins over the fetch increment
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs[15] <= RESET_PC;
        end else if (en) begin
            if (pc_wr) begin
                regs[15] <= wd;
            end else if (pc_inc) begin
                regs[15] <= regs[15] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= '0;
        end else if (flag_go) begin
            flags <= fi;
        end
    end

    assign dbg_o = regs[dbg_a];

`ifdef RFILE2_BYPASS_EN
    always_comb begin
        bo     = regs[ra_b];
        do_val = regs[ra_d];
        pc     = regs[15];
        fo     = flags;
        if (wr_go && (ra_b == wa)) bo = wd;
        if (wr_go && (ra_d == wa)) do_val = wd;
        if (pc_wr) pc = wd;
        if (flag_go) fo = fi;
    end
`else
    always_comb begin
        bo     = regs[ra_b];
        do_val = regs[ra_d];
        pc     = regs[15];
        fo     = flags;
    end
`endif

endmodule

// File: tb/tb_rfile2.sv
// Directed bench for rfile2 with RESET_PC = 32'h100; expectations follow the bypass build when enabled.
module tb_rfile2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  ra_b, ra_d, wa, dbg_a;
    logic [31:0] bo, do_val, wd, pc, dbg_o;
    logic        wb_en, flag_en, pc_inc;
    logic [7:0]  fi, fo;

    int total = 0;
    int bad   = 0;

    rfile2 #(.WIDTH(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .en(en),
        .ra_b(ra_b), .ra_d(ra_d), .bo(bo), .do_val(do_val),
        .wa(wa), .wd(wd), .wb_en(wb_en),
        .fi(fi), .flag_en(flag_en), .fo(fo),
        .pc_inc(pc_inc), .pc(pc),
        .dbg_a(dbg_a), .dbg_o(dbg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef RFILE2_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial begin
        reset = 1'b0; en = 1'b1;
        ra_b = 4'd3; ra_d = 4'd0; dbg_a = 4'd15;
        wa = 4'd3; wd = 32'd5; wb_en = 1'b1;
        fi = 8'h00; flag_en = 1'b0; pc_inc = 1'b0;
        tick();
        tick();
        wb_en = 1'b0;
        #1;
        chk("rst_bo_r3", bo, 32'h0);
        chk("rst_do_r0", do_val, 32'h0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_dbg_r15", dbg_o, 32'h100);
        chk("rst_fo", {24'h0, fo}, 32'h0);
        reset = 1'b1;

        // Plain write, then read on both operand ports
        ra_b = 4'd0; ra_d = 4'd0;
        wa = 4'd7; wd = 32'hDEADBEEF; wb_en = 1'b1;
        tick();
        wb_en = 1'b0; ra_b = 4'd7; ra_d = 4'd7;
        #1;
        chk("wr_bo_r7", bo, 32'hDEADBEEF);
        chk("wr_do_r7", do_val, 32'hDEADBEEF);

        // Stalled write is dropped
        en = 1'b0; wb_en = 1'b1; wa = 4'd7; wd = 32'd1;
        tick();
        en = 1'b1; wb_en = 1'b0;
        #1;
        chk("stall_r7", bo, 32'hDEADBEEF);

        // PC wrap through all-ones
        wa = 4'd15; wd = 32'hFFFFFFFE; wb_en = 1'b1;
        tick();
        wb_en = 1'b0; pc_inc = 1'b1;
        #1;
        chk("pc_load", pc, 32'hFFFFFFFE);
        tick(); chk("pc_inc1", pc, 32'hFFFFFFFF);
        tick(); chk("pc_wrap", pc, 32'h00000000);
        tick(); chk("pc_inc3", pc, 32'h00000001);

        // Write-back to R15 beats pc_inc
        wb_en = 1'b1; wa = 4'd15; wd = 32'h40;
        tick();
        wb_en = 1'b0; pc_inc = 1'b0;
        #1;
        chk("pc_prio", pc, 32'h40);

        // Flags and register written together
        ra_b = 4'd0;
        flag_en = 1'b1; fi = 8'hA5; wb_en = 1'b1; wa = 4'd2; wd = 32'd9;
        tick();
        flag_en = 1'b0; fi = 8'hFF; wb_en = 1'b0; ra_b = 4'd2;
        #1;
        chk("flag_set", {24'h0, fo}, 32'hA5);
        chk("flag_r2", bo, 32'd9);
        tick();
        chk("flag_hold", {24'h0, fo}, 32'hA5);

        // Stall freezes PC and flags
        en = 1'b0; pc_inc = 1'b1; flag_en = 1'b1; fi = 8'h3C;
        tick();
        chk("stall_pc", pc, 32'h40);
        chk("stall_fo", {24'h0, fo}, 32'hA5);
        en = 1'b1; pc_inc = 1'b0; flag_en = 1'b0;

        // R0 is an ordinary register
        wa = 4'd0; wd = 32'h77; wb_en = 1'b1;
        tick();
        wb_en = 1'b0; dbg_a = 4'd0;
        #1;
        chk("r0_write", dbg_o, 32'h77);

        // Read during write
        wa = 4'd4; wd = 32'h11; wb_en = 1'b1; ra_b = 4'd0;
        tick();
        ra_b = 4'd4; dbg_a = 4'd4; wa = 4'd4; wd = 32'h55; wb_en = 1'b1;
        #1;
        chk("rdw_bo", bo, BYP ? 32'h55 : 32'h11);
        chk("rdw_dbg", dbg_o, 32'h11);
        tick();
        wb_en = 1'b0;
        #1;
        chk("rdw_after", bo, 32'h55);

        // Same-cycle flag and PC visibility
        flag_en = 1'b1; fi = 8'h5A; wb_en = 1'b1; wa = 4'd15; wd = 32'h200;
        #1;
        chk("fo_same", {24'h0, fo}, BYP ? 32'h5A : 32'hA5);
        chk("pc_same", pc, BYP ? 32'h200 : 32'h40);
        tick();
        flag_en = 1'b0; wb_en = 1'b0;
        #1;
        chk("fo_next", {24'h0, fo}, 32'h5A);
        chk("pc_next", pc, 32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
